pio_cmd_loader: RTL and testbench
=================================

# pio_cmd_loader

Upstream feeder for the `pio` block. It receives a byte stream from a UART receiver and parses fixed 8-byte command frames. Each frame carries a program word or a configuration write. After the checksum passes, it drives the `pio` load interface (`action`, `din`, `index`, `mindex`) for one cycle. This replaces the hard-coded program/config ROM sequencing, so PIO programs can be loaded at run time from a host.

## Interface
- `SYNC`, 8'hA5, frame start byte.
- `TIMEOUT`, 250000, maximum idle cycles between bytes inside a frame (10 ms at 25 MHz).
- `clk_25mhz`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `rx_data`  in  8  received byte.
- `action`  out  4  pio action code; non-zero for exactly one cycle per accepted frame.
- `din`  out  32  pio data word.
- `index`  out  5  pio instruction index.
- `mindex`  out  2  pio state-machine index.
- `busy`  out  1  high while a frame is partially received.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_data`  out  8  8'h06 (ACK) or 8'h15 (NAK); valid with `resp_valid`.
- `frames_ok`  out  8  count of accepted frames, saturates at 255.
- `frames_err`  out  8  count of rejected frames (checksum error or timeout), saturates at 255.

## Operation
- **Frame layout**, in byte order:
  - B0 = `SYNC`.
  - B1 = {mindex[1:0], 2'b00, action[3:0]}.
  - B2 = {3'bxxx, index[4:0]}.
  - B3..B6 = din, little-endian.
  - B7 = XOR of B1..B6.
- **FSM states** are IDLE, CMD, IDX, DATA, CHK. DATA uses a 2-bit byte counter 0..3.
- **Transitions:**
  - IDLE → CMD on `rx_valid` with `rx_data==SYNC`. Any other byte in IDLE is silently dropped and is not counted.
  - CMD latches action and mindex, then → IDX.
  - IDX latches index[4:0]; the upper 3 bits are ignored but still included in the XOR. Then → DATA.
  - DATA shifts in 4 bytes, then → CHK.
  - CHK → IDLE on the next `rx_valid`. The running XOR (cleared at B0, updated B1..B6) is compared against B7.
- **Match:**
  - Register `action`, `din`, `index`, `mindex` to the frame values; `action` is cleared after one cycle.
  - Issue ACK and increment `frames_ok`.
  - A frame with action 0 is accepted and ACKed but produces no strobe, because the strobe is 0 anyway.
- **Mismatch:** no action strobe. Issue NAK and increment `frames_err`. `din`, `index`, `mindex` keep their previous values.
- **Timeout:**
  - The gap counter is cleared on every `rx_valid` and runs only in states other than IDLE.
  - When it reaches `TIMEOUT`, return to IDLE, issue NAK and increment `frames_err`.
  - If `rx_valid` arrives in the same cycle the count would hit `TIMEOUT`, the byte is processed and no timeout occurs.
- A SYNC-valued byte in the middle of a frame is treated as data; there is no resynchronisation except by timeout.
- `busy` = (state != IDLE).
- `reset` at any point aborts the frame with no response. The next frame parses normally.

## Timing
- **Reset values:**
  - `action`=0, `din`=0, `index`=0, `mindex`=0.
  - `busy`=0, `resp_valid`=0, `resp_data`=0.
  - `frames_ok`=0, `frames_err`=0. The FSM goes to IDLE.
- **Latency:** B7 sampled at edge N. At N+1, `action`, `din`, `index`, `mindex`, `resp_valid` and `resp_data` are valid, and `action` is held for exactly that one cycle. Counters update at N+1 and `busy` is 0 at N+1.
- **Back-to-back frames:** a B0 arriving in the cycle right after B7 is accepted. The FSM is already IDLE after edge N.
- `din`, `index`, `mindex` hold their last accepted values indefinitely. `pio` samples them only when `action`≠0.
- A timeout NAK is asserted in the cycle after the counter reaches `TIMEOUT`.
- All outputs are registered.

## Test plan
- **Program load:** A5 01 00 81 E0 00 00 60 → one cycle with action=1, index=0, din=32'h0000E081, mindex=0; ACK; frames_ok=1.
- **Config to SM2:** A5 87 00 80 02 00 00 05 → action=7, mindex=2, din=32'h00000280; ACK.
- **Bad checksum:** A5 06 00 01 00 00 00 08 → no action strobe, NAK, frames_err=1. Then A5 06 00 01 00 00 00 07 is accepted with action=6, din=1.
- **Junk and timeout:** leading bytes 00 FF → ignored, busy=0. Then A5 01 followed by `TIMEOUT` idle cycles → NAK, busy=0, frames_err=1. A byte arriving on cycle `TIMEOUT`-1 → no timeout.
- **Stream:** 4 valid frames sent back-to-back with `rx_valid` every cycle → 4 strobes with index 0..3, frames_ok=4.
- **Reset mid-frame:** reset after B3 → all outputs at reset values, no response. The following valid frame is accepted.

Source files
------------

// File: rtl/pio_cmd_loader_if.sv
// Byte-stream input and pio load-port outputs of the command loader.
// "slave" is the loader side; "master" is the host/UART/pio side.
interface pio_cmd_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [3:0]  action;
  logic [31:0] din;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic        busy;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic [7:0]  frames_ok;
  logic [7:0]  frames_err;

  modport slave (
    input  rx_valid, rx_data,
    output action, din, index, mindex, busy,
    output resp_valid, resp_data, frames_ok, frames_err
  );

  modport master (
    output rx_valid, rx_data,
    input  action, din, index, mindex, busy,
    input  resp_valid, resp_data, frames_ok, frames_err
  );
endinterface

// File: rtl/pio_cmd_loader.sv
// Parses 8-byte host frames (SYNC, cmd, idx, din LE, XOR) from a UART byte
// stream and drives a one-cycle pio load strobe, with ACK/NAK and counters.
//
// state  | meaning
// S_IDLE | waiting for SYNC; other bytes dropped
// S_CMD  | expecting B1 (mindex, action)
// S_IDX  | expecting B2 (index)
// S_DATA | expecting B3..B6 (din, little-endian)
// S_CHK  | expecting B7 (XOR of B1..B6)
module pio_cmd_loader #(
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int unsigned TIMEOUT = 250000
) (
  input  logic            clk_25mhz,
  input  logic            reset,
  pio_cmd_loader_if.slave bus
);

  localparam int unsigned      GW       = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0]    GAP_LAST = GW'(TIMEOUT - 1);
  localparam logic [7:0]       ACK      = 8'h06;
  localparam logic [7:0]       NAK      = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_IDX,
    S_DATA,
    S_CHK
  } state_t;

  state_t         state_q;
  logic [1:0]     byte_cnt_q;
  logic [7:0]     xor_q;
  logic [GW-1:0]  gap_q;
  logic [3:0]     cmd_action_q;
  logic [1:0]     cmd_mindex_q;
  logic [4:0]     cmd_index_q;
  logic [31:0]    shift_q;

  logic [3:0]     action_q;
  logic [31:0]    din_q;
  logic [4:0]     index_q;
  logic [1:0]     mindex_q;
  logic           busy_q;
  logic           resp_valid_q;
  logic [7:0]     resp_data_q;
  logic [7:0]     frames_ok_q;
  logic [7:0]     frames_err_q;

  logic [7:0]     xor_d;
  logic [31:0]    shift_d;
  logic [7:0]     frames_ok_d;
  logic [7:0]     frames_err_d;

  assign xor_d        = xor_q ^ bus.rx_data;
  assign shift_d      = {bus.rx_data, shift_q[31:8]};
  assign frames_ok_d  = (frames_ok_q  == 8'hFF) ? frames_ok_q  : frames_ok_q  + 8'd1;
  assign frames_err_d = (frames_err_q == 8'hFF) ? frames_err_q : frames_err_q + 8'd1;

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      xor_q        <= '0;
      gap_q        <= '0;
      cmd_action_q <= '0;
      cmd_mindex_q <= '0;
      cmd_index_q  <= '0;
      shift_q      <= '0;
      action_q     <= '0;
      din_q        <= '0;
      index_q      <= '0;
      mindex_q     <= '0;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      frames_ok_q  <= '0;
      frames_err_q <= '0;
    end else begin
      action_q     <= '0;
      resp_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          gap_q <= '0;
          if (bus.rx_valid && bus.rx_data == SYNC) begin
            state_q <= S_CMD;
            busy_q  <= 1'b1;
            xor_q   <= '0;
          end
        end

        default: begin
          if (bus.rx_valid) begin
            // A byte always wins over a timeout landing in the same cycle.
            gap_q <= '0;
            case (state_q)
              S_CMD: begin
                cmd_action_q <= bus.rx_data[3:0];
                cmd_mindex_q <= bus.rx_data[7:6];
                xor_q        <= xor_d;
                state_q      <= S_IDX;
              end
              S_IDX: begin
                cmd_index_q <= bus.rx_data[4:0];
                xor_q       <= xor_d;
                byte_cnt_q  <= '0;
                state_q     <= S_DATA;
              end
              S_DATA: begin
                shift_q    <= shift_d;
                xor_q      <= xor_d;
                byte_cnt_q <= byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                  state_q <= S_CHK;
                end
              end
              S_CHK: begin
                state_q      <= S_IDLE;
                busy_q       <= 1'b0;
                resp_valid_q <= 1'b1;
                if (xor_q == bus.rx_data) begin
                  action_q    <= cmd_action_q;
                  din_q       <= shift_q;
                  index_q     <= cmd_index_q;
                  mindex_q    <= cmd_mindex_q;
                  resp_data_q <= ACK;
                  frames_ok_q <= frames_ok_d;
                end else begin
                  resp_data_q  <= NAK;
                  frames_err_q <= frames_err_d;
                end
              end
              default: begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            endcase
          end else if (gap_q == GAP_LAST) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            gap_q        <= '0;
            resp_valid_q <= 1'b1;
            resp_data_q  <= NAK;
            frames_err_q <= frames_err_d;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.action     = action_q;
  assign bus.din        = din_q;
  assign bus.index      = index_q;
  assign bus.mindex     = mindex_q;
  assign bus.busy       = busy_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.frames_ok  = frames_ok_q;
  assign bus.frames_err = frames_err_q;

endmodule

// File: tb/tb_pio_cmd_loader.sv
// Directed bench for pio_cmd_loader: frame table plus timeout, reset and
// back-to-back stream sequences.
module tb_pio_cmd_loader;

  localparam int unsigned TO  = 40;
  localparam logic [7:0]  ACK = 8'h06;
  localparam logic [7:0]  NAK = 8'h15;

  logic clk_25mhz = 1'b0;
  logic reset     = 1'b1;

  pio_cmd_loader_if bus ();

  pio_cmd_loader #(.SYNC(8'hA5), .TIMEOUT(TO)) dut (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .bus       (bus.slave)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  typedef struct packed {
    logic [63:0] frame;
    logic        ack;
    logic [3:0]  act;
    logic [31:0] din;
    logic [4:0]  idx;
    logic [1:0]  mi;
    logic [7:0]  ok;
    logic [7:0]  err;
  } vec_t;

  vec_t vecs [7];

  int n_total = 0;
  int n_pass  = 0;

  int       strobe_n = 0;
  logic [4:0] strobe_idx [32];

  always @(negedge clk_25mhz) begin
    if (bus.action != 4'd0) begin
      if (strobe_n < 32) strobe_idx[strobe_n] = bus.index;
      strobe_n = strobe_n + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk_25mhz);
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_accept(input string name, input vec_t v);
    check({name, " resp_valid"}, 32'(bus.resp_valid), 32'd1);
    check({name, " resp_data"},  32'(bus.resp_data),  v.ack ? 32'(ACK) : 32'(NAK));
    check({name, " action"},     32'(bus.action),     v.ack ? 32'(v.act) : 32'd0);
    check({name, " din"},        bus.din,             v.din);
    check({name, " index"},      32'(bus.index),      32'(v.idx));
    check({name, " mindex"},     32'(bus.mindex),     32'(v.mi));
    check({name, " busy"},       32'(bus.busy),       32'd0);
    check({name, " frames_ok"},  32'(bus.frames_ok),  32'(v.ok));
    check({name, " frames_err"}, 32'(bus.frames_err), 32'(v.err));
    @(negedge clk_25mhz);
    check({name, " action 1cyc"}, 32'(bus.action),     32'd0);
    check({name, " resp 1cyc"},   32'(bus.resp_valid), 32'd0);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " action"},     32'(bus.action),     32'd0);
    check({name, " din"},        bus.din,             32'd0);
    check({name, " index"},      32'(bus.index),      32'd0);
    check({name, " mindex"},     32'(bus.mindex),     32'd0);
    check({name, " busy"},       32'(bus.busy),       32'd0);
    check({name, " resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({name, " resp_data"},  32'(bus.resp_data),  32'd0);
    check({name, " frames_ok"},  32'(bus.frames_ok),  32'd0);
    check({name, " frames_err"}, 32'(bus.frames_err), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   cycles;
    logic saw_resp;
    int   base;

    //               frame                   ack act  din           idx    mi   ok  err
    vecs[0] = '{64'hA501_0081_E000_0060, 1'b1, 4'd1, 32'h0000E081, 5'd0,  2'd0, 8'd1, 8'd0};
    vecs[1] = '{64'hA587_0080_0200_0005, 1'b1, 4'd7, 32'h00000280, 5'd0,  2'd2, 8'd2, 8'd0};
    vecs[2] = '{64'hA506_0001_0000_0008, 1'b0, 4'd0, 32'h00000280, 5'd0,  2'd2, 8'd2, 8'd1};
    vecs[3] = '{64'hA506_0001_0000_0007, 1'b1, 4'd6, 32'h00000001, 5'd0,  2'd0, 8'd3, 8'd1};
    vecs[4] = '{64'hA5C3_E578_5634_122E, 1'b1, 4'd3, 32'h12345678, 5'd5,  2'd3, 8'd4, 8'd1};
    vecs[5] = '{64'hA540_1F11_2233_441B, 1'b1, 4'd0, 32'h44332211, 5'd31, 2'd1, 8'd5, 8'd1};
    vecs[6] = '{64'hA502_01A5_A5A5_A503, 1'b1, 4'd2, 32'hA5A5A5A5, 5'd1,  2'd0, 8'd6, 8'd1};

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk_25mhz);
    reset = 1'b0;
    check_reset_vals("reset");

    // Junk before any SYNC is dropped silently.
    send_byte(8'h00);
    check("junk00 busy", 32'(bus.busy), 32'd0);
    send_byte(8'hFF);
    check("junkFF busy", 32'(bus.busy), 32'd0);
    check("junk resp",   32'(bus.resp_valid), 32'd0);
    check("junk err",    32'(bus.frames_err), 32'd0);

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      @(negedge clk_25mhz);
      for (int k = 0; k < 8; k++) begin
        send_byte(v.frame[63-8*k -: 8]);
        if (k == 3) check($sformatf("f%0d busy mid", i), 32'(bus.busy), 32'd1);
      end
      check_accept($sformatf("f%0d", i), v);
    end

    // Timeout: SYNC + B1 then silence.
    send_byte(8'hA5);
    send_byte(8'h01);
    cycles = 1;
    while (!bus.resp_valid && cycles < int'(TO) + 10) begin
      @(negedge clk_25mhz);
      cycles++;
    end
    check("timeout cycle",    32'(cycles),           32'(TO + 1));
    check("timeout resp",     32'(bus.resp_valid),   32'd1);
    check("timeout nak",      32'(bus.resp_data),    32'(NAK));
    check("timeout busy",     32'(bus.busy),         32'd0);
    check("timeout err",      32'(bus.frames_err),   32'd2);
    check("timeout action",   32'(bus.action),       32'd0);
    @(negedge clk_25mhz);

    // Byte arriving on cycle TO-1 of silence keeps the frame alive.
    send_byte(8'hA5);
    send_byte(8'h01);
    saw_resp = 1'b0;
    repeat (TO - 2) begin
      if (bus.resp_valid) saw_resp = 1'b1;
      @(negedge clk_25mhz);
    end
    v = '{64'hA501_0081_E000_0060, 1'b1, 4'd1, 32'h0000E081, 5'd0, 2'd0, 8'd7, 8'd2};
    for (int k = 2; k < 8; k++) begin
      if (bus.resp_valid) saw_resp = 1'b1;
      send_byte(v.frame[63-8*k -: 8]);
    end
    check("late byte no timeout", 32'(saw_resp), 32'd0);
    check_accept("late", v);

    // Reset after B3 aborts the frame silently.
    send_byte(8'hA5);
    send_byte(8'h87);
    send_byte(8'h00);
    send_byte(8'h80);
    reset = 1'b1;
    @(negedge clk_25mhz);
    reset = 1'b0;
    check_reset_vals("midreset");
    @(negedge clk_25mhz);
    check("midreset resp", 32'(bus.resp_valid), 32'd0);
    v = '{64'hA587_0080_0200_0005, 1'b1, 4'd7, 32'h00000280, 5'd0, 2'd2, 8'd1, 8'd0};
    for (int k = 0; k < 8; k++) send_byte(v.frame[63-8*k -: 8]);
    check_accept("postreset", v);

    // Fresh reset, then four frames with rx_valid every cycle.
    reset = 1'b1;
    @(negedge clk_25mhz);
    reset = 1'b0;
    @(negedge clk_25mhz);
    base = strobe_n;
    for (int f = 0; f < 4; f++) begin
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'(f));
      send_byte(8'(f));
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h01);
    end
    repeat (2) @(negedge clk_25mhz);
    check("stream strobes",   32'(strobe_n - base),   32'd4);
    for (int f = 0; f < 4; f++) begin
      check($sformatf("stream idx%0d", f), 32'(strobe_idx[(base + f) % 32]), 32'(f));
    end
    check("stream frames_ok", 32'(bus.frames_ok),  32'd4);
    check("stream frames_err", 32'(bus.frames_err), 32'd0);
    check("stream din",       bus.din,             32'h00000003);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
